mod3_arbiter: RTL and testbench
===============================

MOD3_ARBITER -- requirements
Module: mod3_arbiter

Interface
REQ-001 SHALL have parameter NREQ, 4, number of requesters; power of two, 2..8.
REQ-002 SHALL have parameter W, 64, operand width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port req_data  input  NREQ*W  packed operands; requester i at bits [i*W +: W].
REQ-007 SHALL have port req_ready  output  NREQ  per-requester accept strobe; at most one bit high.
REQ-008 SHALL have port rsp_valid  output  1  result valid.
REQ-009 SHALL have port rsp_ready  input  1  downstream accepts result.
REQ-010 SHALL have port rsp_id  output  log2(NREQ)  requester index of result.
REQ-011 SHALL have port rsp_rem  output  2  operand mod 3, range 0..2.
REQ-012 SHALL have port busy  output  1  high when any pipeline stage holds a valid entry.

Function
REQ-013 SHALL share one mod-3 residue datapath among NREQ requesters through a 2-stage pipeline: S1 = registered operand+id, S2 = registered residue+id (S2 drives rsp_*).
REQ-014 SHALL define advance enable adv = !S2.valid || rsp_ready; all stages hold when adv is low.
REQ-015 SHALL grant round-robin: highest priority is index ptr, then ptr+1, ... wrapping modulo NREQ.
REQ-016 SHALL drive req_ready[i] high only when i is the granted requester, req_valid[i] is high and adv is high; grant is combinational from req_valid and ptr.
REQ-017 SHALL treat a transfer as req_valid[i] && req_ready[i] in the same cycle; the operand loads into S1 with id i.
REQ-018 SHALL update ptr to (granted index + 1) mod NREQ only on a transfer; ptr holds otherwise.
REQ-019 SHALL, when adv is high, move S1 into S2 computing rsp_rem = S1.data mod 3, and load S1 valid = transfer occurred this cycle.
REQ-020 SHALL produce rsp_valid exactly 2 cycles after a transfer when rsp_ready stays high (transfer at edge N, rsp_valid high after edge N+2).
REQ-021 SHALL sustain one transfer per cycle with rsp_ready held high; no bubble between back-to-back requests.
REQ-022 SHALL hold rsp_valid, rsp_id, rsp_rem stable while rsp_valid && !rsp_ready.
REQ-023 SHALL drop nothing and duplicate nothing under any rsp_ready pattern; result order equals transfer order.
REQ-024 SHALL keep rsp_id and rsp_rem at 0 when rsp_valid is low after reset; stale values otherwise allowed only while rsp_valid is low.
REQ-025 SHALL drive busy = S1.valid || S2.valid.
REQ-026 SHALL ignore req_data of requesters not transferring; a requester deasserting req_valid without transfer is legal.

Reset
REQ-027 SHALL on rst_n low clear S1/S2 valid, data, id and residue to 0 and set ptr to 0, asynchronously.
REQ-028 SHALL drive req_ready=0, rsp_valid=0, rsp_id=0, rsp_rem=0, busy=0 during reset.
REQ-029 SHALL discard in-flight entries on reset mid-operation; first post-reset grant goes to lowest valid index.

Structure
REQ-030 SHALL place NREQ default, W default and ID width (log2 NREQ) constants in a shared package.
REQ-031 SHALL instantiate one combinational sub-module mod3_residue (W-bit in, 2-bit out) between S1 and S2.
REQ-032 SHALL keep arbitration, ptr and pipeline control in mod3_arbiter itself.

Verification
REQ-033 SHALL check: req0 sends 64'd10, rsp_ready=1 -> rsp_valid 2 cycles later, rsp_id=0, rsp_rem=1.
REQ-034 SHALL check: after reset all four req_valid high with operands 3,4,5,2^64-1 -> results in id order 0,1,2,3, rem 0,1,2,0, one per cycle.
REQ-035 SHALL check: rsp_ready low 3 cycles with both stages full -> req_ready all 0, rsp_* stable, busy=1; on release results resume in order, none lost.
REQ-036 SHALL check: req1 and req3 continuously valid -> grants alternate 1,3,1,3.
REQ-037 SHALL check: rst_n asserted with 2 entries in flight -> rsp_valid=0 and busy=0 immediately; no stale result after release.
REQ-038 SHALL check: 10,000 random operands, random req_valid/rsp_ready -> every rsp_rem equals operand mod 3 per scoreboard.

Source files
------------

// File: rtl/mod3_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mod3_arbiter_pkg
//   Shared constants and helpers for the mod-3 residue arbiter.
//   - NREQ_DEF : default number of requesters (power of two, 2..8)
//   - W_DEF    : default operand width in bits
//   - ID_W_DEF : requester index width for the default NREQ
//   - add_mod3 : folds one 2-bit digit (0..3) into a running residue (0..2)
// -----------------------------------------------------------------------------
package mod3_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 64;
  localparam int ID_W_DEF = $clog2(NREQ_DEF);

  // Since 4 == 1 (mod 3), every base-4 digit contributes its own value to the
  // residue, so the residue of a word is the mod-3 sum of its 2-bit digits.
  // acc is already reduced (0..2); digit may be 0..3, so the sum is 0..5 and
  // a single conditional subtract brings it back into range.
  function automatic logic [1:0] add_mod3(input logic [1:0] acc, input logic [1:0] digit);
    logic [2:0] sum;
    sum = {1'b0, acc} + {1'b0, digit};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

endpackage

// File: rtl/mod3_residue.sv
// -----------------------------------------------------------------------------
// mod3_residue
//   Purely combinational W-bit mod-3 reducer shared by all requesters.
//   Ports:
//     operand : input  [W-1:0]  value to reduce
//     residue : output [1:0]    operand mod 3, always 0..2
// -----------------------------------------------------------------------------
module mod3_residue
  import mod3_arbiter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] operand,
  output logic [1:0]   residue
);

  // Number of 2-bit digits; an odd width is padded with a zero MSB.
  localparam int NDIG = (W + 1) / 2;

  logic [2*NDIG-1:0] pad_s;
  logic [1:0]        acc_s;

  // Zero-extend the operand to a whole number of base-4 digits.
  always_comb begin
    pad_s          = '0;
    pad_s[W-1:0]   = operand;
  end

  // Fold every base-4 digit into the running residue.
  always_comb begin
    acc_s = 2'd0;
    for (int d = 0; d < NDIG; d++) begin
      acc_s = add_mod3(acc_s, pad_s[2*d +: 2]);
    end
  end

  assign residue = acc_s;

endmodule

// File: rtl/mod3_arbiter.sv
// -----------------------------------------------------------------------------
// mod3_arbiter
//   Round-robin arbiter in front of one shared mod-3 residue datapath with a
//   two-stage valid/ready pipeline (S1: operand+id, S2: residue+id).
//   Ports:
//     clk       : input             clock, rising edge
//     rst_n     : input             asynchronous active-low reset
//     req_valid : input  [NREQ-1:0] per-requester operand valid
//     req_data  : input  [NREQ*W-1:0] packed operands, requester i at [i*W +: W]
//     req_ready : output [NREQ-1:0] per-requester accept strobe (one-hot or 0)
//     rsp_valid : output            result valid
//     rsp_ready : input             downstream accepts result
//     rsp_id    : output [log2 NREQ-1:0] requester index of the result
//     rsp_rem   : output [1:0]      operand mod 3
//     busy      : output            any pipeline stage holds a valid entry
// -----------------------------------------------------------------------------
module mod3_arbiter
  import mod3_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [1:0]               rsp_rem,
  output logic                     busy
);

  localparam int ID_W = $clog2(NREQ);

  // Round-robin pointer: index with highest priority this cycle.
  logic [ID_W-1:0] ptr_r;

  // Stage 1: captured operand and its requester id.
  logic            s1_valid_r;
  logic [W-1:0]    s1_data_r;
  logic [ID_W-1:0] s1_id_r;

  // Stage 2: residue and requester id; drives the response outputs.
  logic            s2_valid_r;
  logic [1:0]      s2_rem_r;
  logic [ID_W-1:0] s2_id_r;

  logic            adv_s;
  logic            grant_any_s;
  logic [ID_W-1:0] grant_idx_s;
  logic [ID_W-1:0] cand_s;
  logic            xfer_s;
  logic [W-1:0]    xfer_data_s;
  logic [NREQ-1:0] req_ready_s;
  logic [1:0]      res_s;

  // The whole pipeline moves together: it can advance whenever the output
  // slot is empty or is being drained this cycle.
  assign adv_s = !s2_valid_r || rsp_ready;

  // Round-robin search starting at ptr; NREQ is a power of two so the
  // ID_W-bit addition wraps modulo NREQ on its own.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = ptr_r + ID_W'(k);
      if (!grant_any_s && req_valid[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_any_s = grant_any_s;
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // A transfer needs a grant and room to move. rst_n gates the strobe so no
  // requester sees an accept while the block is held in reset.
  assign xfer_s = grant_any_s && adv_s && rst_n;

  // One-hot accept strobe for the granted requester.
  always_comb begin
    req_ready_s = '0;
    if (xfer_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Select the granted requester's operand for loading into S1.
  always_comb begin
    xfer_data_s = req_data[grant_idx_s*W +: W];
  end

  // Shared residue datapath between S1 and S2.
  mod3_residue #(
    .W (W)
  ) u_residue (
    .operand (s1_data_r),
    .residue (res_s)
  );

  // Round-robin pointer: moves just past the winner, only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      ptr_r <= grant_idx_s + ID_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Stage 1 register: valid follows the transfer; payload only loads on one,
  // so idle cycles leave a harmless stale operand behind a low valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_id_r    <= '0;
    end else if (adv_s) begin
      s1_valid_r <= xfer_s;
      if (xfer_s) begin
        s1_data_r <= xfer_data_s;
        s1_id_r   <= grant_idx_s;
      end else begin
        s1_data_r <= s1_data_r;
        s1_id_r   <= s1_id_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_data_r  <= s1_data_r;
      s1_id_r    <= s1_id_r;
    end
  end

  // Stage 2 register: payload only updates from a valid S1 entry, which keeps
  // rsp_id/rsp_rem at zero after reset until the first real result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_rem_r   <= 2'd0;
      s2_id_r    <= '0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_rem_r <= res_s;
        s2_id_r  <= s1_id_r;
      end else begin
        s2_rem_r <= s2_rem_r;
        s2_id_r  <= s2_id_r;
      end
    end else begin
      s2_valid_r <= s2_valid_r;
      s2_rem_r   <= s2_rem_r;
      s2_id_r    <= s2_id_r;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = s2_valid_r;
  assign rsp_id    = s2_id_r;
  assign rsp_rem   = s2_rem_r;
  assign busy      = s1_valid_r || s2_valid_r;

endmodule

// File: tb/tb_mod3_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mod3_arbiter
//   Directed and random stimulus for mod3_arbiter (NREQ=4, W=64). A small
//   cycle model tracks stage valids and the round-robin pointer; expected
//   {id, residue} pairs are queued at each transfer and compared when the
//   result reaches the output.
// -----------------------------------------------------------------------------
module tb_mod3_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [1:0]        rsp_rem;
  logic              busy;

  logic [W-1:0] ops [NREQ];

  typedef struct {
    logic [1:0] id;
    logic [1:0] rem;
  } exp_t;

  exp_t sbq [$];
  bit   m_s1_v;
  bit   m_s2_v;
  int   m_ptr;
  int   obs_grant;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Pack the per-requester operands onto the bus.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*W +: W] = ops[i];
    end
  end

  mod3_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_rem   (rsp_rem),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    m_s1_v = 1'b0;
    m_s2_v = 1'b0;
    m_ptr  = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the
  // model with the same inputs at the rising edge.
  task automatic step();
    bit          adv_m;
    int          g;
    int          c;
    logic [3:0]  exp_rdy;
    exp_t        e;
    @(negedge clk);
    adv_m = !m_s2_v || rsp_ready;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      c = (m_ptr + k) % NREQ;
      if (g < 0 && req_valid[c]) g = c;
    end
    exp_rdy = 4'b0000;
    if (adv_m && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_s2_v));
    chk("busy", 64'(busy), 64'(m_s1_v | m_s2_v));
    if (m_s2_v && sbq.size() > 0) begin
      chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
      chk("rsp_rem", 64'(rsp_rem), 64'(sbq[0].rem));
    end
    obs_grant = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] === 1'b1) obs_grant = i;
    end
    @(posedge clk);
    if (m_s2_v && rsp_ready && sbq.size() > 0) void'(sbq.pop_front());
    if (adv_m) begin
      m_s2_v = m_s1_v;
      m_s1_v = (g >= 0);
      if (g >= 0) begin
        e.id  = 2'(g);
        e.rem = 2'(ops[g] % 64'd3);
        sbq.push_back(e);
        m_ptr = (g + 1) % NREQ;
      end
    end
    #1;
  endtask

  // Assert reset between edges, check reset outputs, release after two edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_rem", 64'(rsp_rem), 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int   t2_rem [4];
    logic [1:0] sav_id;
    logic [1:0] sav_rem;
    t2_rem = '{0, 1, 2, 0};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) ops[i] = 64'd0;
    model_reset();

    // Reset state, with every requester asking: nothing may be accepted.
    @(posedge clk);
    #1;
    chk("rst0_req_ready", 64'(req_ready), 64'd0);
    chk("rst0_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst0_busy", 64'(busy), 64'd0);
    req_valid = 4'b0000;
    do_reset();
    step();
    chk("idle_rsp_id", 64'(rsp_id), 64'd0);
    chk("idle_rsp_rem", 64'(rsp_rem), 64'd0);

    // Single operand 10 from requester 0: result two cycles later.
    ops[0]    = 64'd10;
    req_valid = 4'b0001;
    step();
    chk("t1_grant", 64'(obs_grant), 64'd0);
    req_valid = 4'b0000;
    chk("t1_lat1_valid", 64'(rsp_valid), 64'd0);
    step();
    chk("t1_lat2_valid", 64'(rsp_valid), 64'd1);
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_rem", 64'(rsp_rem), 64'd1);
    step();

    // All four requesters at once after reset: id order 0..3, one per cycle.
    do_reset();
    ops[0] = 64'd3;
    ops[1] = 64'd4;
    ops[2] = 64'd5;
    ops[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 4) begin
        chk("t2_grant", 64'(obs_grant), 64'(i));
        req_valid[i] = 1'b0;
      end
      if (i >= 1 && i <= 4) begin
        chk("t2_valid", 64'(rsp_valid), 64'd1);
        chk("t2_id", 64'(rsp_id), 64'(i - 1));
        chk("t2_rem", 64'(rsp_rem), 64'(t2_rem[i-1]));
      end
    end

    // Backpressure with both stages full: everything holds for three cycles.
    ops[0]    = 64'd7;
    ops[1]    = 64'd8;
    req_valid = 4'b0011;
    repeat (3) step();
    rsp_ready = 1'b0;
    sav_id    = rsp_id;
    sav_rem   = rsp_rem;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_req_ready", 64'(req_ready), 64'd0);
      chk("t3_busy", 64'(busy), 64'd1);
      chk("t3_valid", 64'(rsp_valid), 64'd1);
      chk("t3_id_hold", 64'(rsp_id), 64'(sav_id));
      chk("t3_rem_hold", 64'(rsp_rem), 64'(sav_rem));
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    repeat (4) step();
    chk("t3_drained", 64'(busy), 64'd0);

    // Requesters 1 and 3 always valid: grants alternate 1,3,1,3.
    do_reset();
    ops[1]    = 64'd100;
    ops[3]    = 64'd101;
    req_valid = 4'b1010;
    step();
    chk("t4_grant0", 64'(obs_grant), 64'd1);
    step();
    chk("t4_grant1", 64'(obs_grant), 64'd3);
    step();
    chk("t4_grant2", 64'(obs_grant), 64'd1);
    step();
    chk("t4_grant3", 64'(obs_grant), 64'd3);

    // Reset with two entries in flight: outputs clear at once, nothing stale.
    req_valid = 4'b0000;
    do_reset();
    repeat (3) step();
    req_valid = 4'b0110;
    step();
    chk("t5_first_grant", 64'(obs_grant), 64'd1);
    req_valid = 4'b0000;
    repeat (3) step();

    // Random operands, request patterns and backpressure.
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 7))
          0:       ops[i] = 64'hFFFF_FFFF_FFFF_FFFF;
          1:       ops[i] = 64'd0;
          default: ops[i] = {$urandom, $urandom};
        endcase
      end
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("final_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
